mux_arbiter_rr: RTL and testbench
=================================

# mux_arbiter_rr

Round-robin arbiter and sequencer for the 2-bit 2:1 multiplexer datapath. Two requesters each present `WIDTH`-bit data with a valid/ready handshake. The block grants one requester at a time, drives the mux `selector` from its grant state, and registers the chosen data into a single output stage with downstream backpressure. It sits in front of `mux_conductual` and its synthesized equivalents and provides their `selector` input.

## Interface

- `WIDTH`, default 2: data width of each input and of the output.
- `BURST_MAX`, default 4: maximum consecutive beats granted to one requester while the other is waiting. Must be at least 1.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_L`  in  1  synchronous, active-low reset.
- `valid_in0`  in  1  requester 0 has data.
- `data_in0`  in  WIDTH  requester 0 data.
- `ready_out0`  out  1  requester 0 beat accepted this cycle when it is high together with `valid_in0`.
- `valid_in1`  in  1  requester 1 has data.
- `data_in1`  in  WIDTH  requester 1 data.
- `ready_out1`  out  1  requester 1 accept, same meaning as `ready_out0`.
- `selector`  out  1  mux select; 1 in GRANT1, 0 otherwise.
- `data_out`  out  WIDTH  registered output data.
- `valid_out`  out  1  `data_out` holds a beat.
- `ready_in`  in  1  downstream can take `data_out`.

## Operation

- Requesters hold `valid_inX` and `data_inX` stable until accepted.
- The FSM has three states: IDLE, GRANT0 and GRANT1. It also keeps a `last_grant` bit and a burst counter `cnt` of width clog2(BURST_MAX+1).
- Output stage space: `space = !valid_out || ready_in`.
- Ready outputs: `ready_outX = (state == GRANTX) && space`. These are combinational from `ready_in`. Define `accX = valid_inX && ready_outX`.
- Output register:
  - On `accX`: `data_out <= data_inX` and `valid_out <= 1`.
  - Otherwise, if `ready_in`: `valid_out <= 0`.
- IDLE transitions:
  - Only one input valid: go to that GRANT.
  - Both inputs valid: go to the GRANT not equal to `last_grant`.
  - No input valid: stay in IDLE.
  - `cnt <= 0` on every exit from IDLE.
- GRANTX transitions, evaluated in priority order (Y is the other input):
  1. `!valid_inX`: go to GRANTY if `valid_inY`, otherwise IDLE. `cnt <= 0`.
  2. `accX && cnt+1 == BURST_MAX`: go to GRANTY if `valid_inY`, otherwise stay in GRANTX. `cnt <= 0` in both cases.
  3. Otherwise: stay in GRANTX and `cnt <= cnt + accX`.
- `last_grant <= X` on every `accX`.
- Only one of `acc0`/`acc1` can be high in a cycle, so the output register never sees simultaneous writes.
- A switch caused by a dropped valid costs one bubble cycle. A switch caused by the burst limit costs none.

## Timing

- Reset values, applied when `reset_L` is low at a clock edge:
  - state IDLE, `selector` 0, `ready_out0` 0, `ready_out1` 0.
  - `valid_out` 0, `data_out` 0, `cnt` 0, `last_grant` 1, so input 0 wins the first tie.
- Reset mid-burst drops any beat held in the output register. No partial grant survives reset.
- Latency from `valid_inX` rising in IDLE:
  - Cycle N: valid seen.
  - N+1: grant; `selector` and `ready_outX` high.
  - N+2: `valid_out` high with that data.
- Steady-state throughput is one beat per cycle while `ready_in` stays high.
- With `ready_in` low and `valid_out` high, both `ready_outX` are low and `data_out` holds. No beat is lost or duplicated.
- `selector` changes only on a clock edge, together with the state.

## Configuration

- `MUX_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority, with input 0 always winning.
    - IDLE with both inputs valid goes to GRANT0.
    - In GRANT1, after any `acc1` with `valid_in0` high, the next state is GRANT0.
    - GRANT0 has no burst limit. `BURST_MAX` and `last_grant` do not affect decisions.
  - Not defined: round-robin with the burst limit, as described in Operation.

## Test plan

- Reset: hold `reset_L` low for 2 cycles with both inputs valid. Required: all outputs 0 and `selector` 0 during reset. After release, the first beat comes from input 0.
- Single requester: `valid_in1` held high for 6 beats, with `data_in1` stepping 0,1,2,3,0,1 on each accept, and `ready_in` held at 1. Required: `selector` 1 from cycle N+1. `data_out` shows 0,1,2,3,0,1 on consecutive cycles from N+2.
- Contention, BURST_MAX=4: both inputs always valid, `data_in0`=2'b01, `data_in1`=2'b10. Required: `data_out` pattern is 4×01 then 4×10, repeating, with no bubble cycles.
- Backpressure: deassert `ready_in` for 3 cycles mid-burst. Required: `data_out` is frozen, `ready_out0`/`ready_out1` are 0, and no beat is skipped or repeated after release.
- Valid drop: input 0 drops valid after 2 beats while input 1 is waiting. Required: one bubble cycle, then `selector` goes to 1 and input 1 data appears.
- With `MUX_ARB_FIXED_PRIO_EN` defined, both inputs always valid. Required: `data_out` is only 01 and `selector` stays at 0.

Source files
------------

// File: rtl/mux_arbiter_rr.sv
// mux_arbiter_rr: two-requester arbiter that drives the 2:1 mux selector and
// registers the granted beat into a single output stage with backpressure.
// Default build is round-robin with a per-requester burst limit.
// Define MUX_ARB_FIXED_PRIO_EN for fixed priority (input 0 always wins).
module mux_arbiter_rr #(
    parameter int unsigned WIDTH     = 2,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             valid_in0,
    input  logic [WIDTH-1:0] data_in0,
    output logic             ready_out0,
    input  logic             valid_in1,
    input  logic [WIDTH-1:0] data_in1,
    output logic             ready_out1,
    output logic             selector,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    input  logic             ready_in
);

    localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   data_out_q, data_out_d;
    logic               valid_out_q, valid_out_d;
    logic               selector_q, selector_d;

    logic               space;
    logic               acc0;
    logic               acc1;
    logic               burst_done;

    // Handshake: a grant accepts only when the output stage can take the beat.
    always_comb begin
        space      = !valid_out_q || ready_in;
        ready_out0 = (state_q == GRANT0) && space;
        ready_out1 = (state_q == GRANT1) && space;
        acc0       = valid_in0 && ready_out0;
        acc1       = valid_in1 && ready_out1;
        burst_done = ((32'(cnt_q) + 32'd1) == BURST_MAX);
    end

    // Grant sequencing: next state, burst counter, tie-break history, selector.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (valid_in0 && valid_in1) begin
`ifdef MUX_ARB_FIXED_PRIO_EN
                    state_d = GRANT0;
`else
                    state_d = last_grant_q ? GRANT0 : GRANT1;
`endif
                end else if (valid_in0) begin
                    state_d = GRANT0;
                end else if (valid_in1) begin
                    state_d = GRANT1;
                end
            end

            GRANT0: begin
                if (!valid_in0) begin
                    state_d = valid_in1 ? GRANT1 : IDLE;
                    cnt_d   = '0;
                end
`ifndef MUX_ARB_FIXED_PRIO_EN
                else if (acc0 && burst_done) begin
                    if (valid_in1) begin
                        state_d = GRANT1;
                    end
                    cnt_d = '0;
                end
`endif
                else begin
                    cnt_d = cnt_q + CNT_W'(acc0);
                end
            end

            GRANT1: begin
                if (!valid_in1) begin
                    state_d = valid_in0 ? GRANT0 : IDLE;
                    cnt_d   = '0;
                end
`ifdef MUX_ARB_FIXED_PRIO_EN
                else if (acc1 && valid_in0) begin
                    state_d = GRANT0;
                    cnt_d   = '0;
                end
`endif
                else if (acc1 && burst_done) begin
                    if (valid_in0) begin
                        state_d = GRANT0;
                    end
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(acc1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (acc0) begin
            last_grant_d = 1'b0;
        end else if (acc1) begin
            last_grant_d = 1'b1;
        end

        selector_d = (state_d == GRANT1);
    end

    // Output stage: capture the accepted beat, retire it when downstream takes it.
    always_comb begin
        data_out_d  = data_out_q;
        valid_out_d = valid_out_q;
        if (acc0) begin
            data_out_d  = data_in0;
            valid_out_d = 1'b1;
        end else if (acc1) begin
            data_out_d  = data_in1;
            valid_out_d = 1'b1;
        end else if (ready_in) begin
            valid_out_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            data_out_q   <= '0;
            valid_out_q  <= 1'b0;
            selector_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            data_out_q   <= data_out_d;
            valid_out_q  <= valid_out_d;
            selector_q   <= selector_d;
        end
    end

    assign selector  = selector_q;
    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;

endmodule

// File: tb/tb_mux_arbiter_rr.sv
// Testbench for mux_arbiter_rr: directed vector table, hand-written corner
// sequences and randomized traffic checked against a behavioural model.
module tb_mux_arbiter_rr;

    localparam int unsigned WIDTH     = 2;
    localparam int unsigned BURST_MAX = 4;

    logic             clk = 1'b0;
    logic             reset_L;
    logic             valid_in0, valid_in1, ready_in;
    logic [WIDTH-1:0] data_in0, data_in1;
    logic             ready_out0, ready_out1, selector, valid_out;
    logic [WIDTH-1:0] data_out;

    always #5 clk = ~clk;

    mux_arbiter_rr #(.WIDTH(WIDTH), .BURST_MAX(BURST_MAX)) dut (
        .clk(clk), .reset_L(reset_L),
        .valid_in0(valid_in0), .data_in0(data_in0), .ready_out0(ready_out0),
        .valid_in1(valid_in1), .data_in1(data_in1), .ready_out1(ready_out1),
        .selector(selector), .data_out(data_out), .valid_out(valid_out),
        .ready_in(ready_in)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: who owns the mux (-1 none), beats in current burst,
    // who was served last, and the content of the output stage.
    int               m_owner = -1;
    int               m_beats = 0;
    int               m_last  = 1;
    bit               m_vout  = 1'b0;
    logic [WIDTH-1:0] m_dout  = '0;
    bit               m_known = 1'b0;
    bit               m_acc0  = 1'b0;
    bit               m_acc1  = 1'b0;

    typedef struct {
        logic             rst_n;
        logic             v0;
        logic [WIDTH-1:0] d0;
        logic             v1;
        logic [WIDTH-1:0] d1;
        logic             rdy;
        logic             e_sel;
        logic             e_r0;
        logic             e_r1;
        logic             e_vo;
        logic [WIDTH-1:0] e_do;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT outputs against the model for the current inputs.
    task automatic settle_check();
        bit sp;
        #1;
        if (m_known) begin
            sp = !m_vout || ready_in;
            chk("model_sel",  32'(selector),   32'(m_owner == 1));
            chk("model_rdy0", 32'(ready_out0), 32'((m_owner == 0) && sp));
            chk("model_rdy1", 32'(ready_out1), 32'((m_owner == 1) && sp));
            chk("model_vout", 32'(valid_out),  32'(m_vout));
            chk("model_dout", 32'(data_out),   32'(m_dout));
        end
    endtask

    // Advance the model by one clock using the current inputs, then clock the DUT.
    task automatic advance();
        bit sp, a0, a1, vx, vy, ax;
        int x;
        sp = !m_vout || ready_in;
        a0 = valid_in0 && (m_owner == 0) && sp;
        a1 = valid_in1 && (m_owner == 1) && sp;
        if (!reset_L) begin
            m_owner = -1; m_beats = 0; m_last = 1; m_vout = 1'b0; m_dout = '0;
            m_known = 1'b1;
            a0 = 1'b0; a1 = 1'b0;
        end else begin
            if (m_owner < 0) begin
                m_beats = 0;
                if (valid_in0 && valid_in1) begin
`ifdef MUX_ARB_FIXED_PRIO_EN
                    m_owner = 0;
`else
                    m_owner = 1 - m_last;
`endif
                end else if (valid_in0) m_owner = 0;
                else if (valid_in1) m_owner = 1;
            end else begin
                x  = m_owner;
                vx = (x == 1) ? valid_in1 : valid_in0;
                vy = (x == 1) ? valid_in0 : valid_in1;
                ax = a0 || a1;
                if (!vx) begin
                    m_owner = vy ? 1 - x : -1;
                    m_beats = 0;
                end else if (ax) begin
                    m_beats++;
`ifdef MUX_ARB_FIXED_PRIO_EN
                    if (x == 1 && vy) begin
                        m_owner = 0; m_beats = 0;
                    end else if (x == 1 && m_beats == BURST_MAX) begin
                        m_beats = 0;
                    end
`else
                    if (m_beats == BURST_MAX) begin
                        if (vy) m_owner = 1 - x;
                        m_beats = 0;
                    end
`endif
                end
            end
            if (a0) begin
                m_dout = data_in0; m_vout = 1'b1; m_last = 0;
            end else if (a1) begin
                m_dout = data_in1; m_vout = 1'b1; m_last = 1;
            end else if (ready_in) begin
                m_vout = 1'b0;
            end
        end
        m_acc0 = a0;
        m_acc1 = a1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        settle_check(); advance();
        settle_check(); advance();
        reset_L = 1'b1;
    endtask

    function automatic vec_t mk(input logic rst_n, input logic v0, input logic [WIDTH-1:0] d0,
                                input logic v1, input logic [WIDTH-1:0] d1, input logic rdy,
                                input logic s, input logic r0, input logic r1,
                                input logic vo, input logic [WIDTH-1:0] dd);
        vec_t t;
        t.rst_n = rst_n; t.v0 = v0; t.d0 = d0; t.v1 = v1; t.d1 = d1; t.rdy = rdy;
        t.e_sel = s; t.e_r0 = r0; t.e_r1 = r1; t.e_vo = vo; t.e_do = dd;
        return t;
    endfunction

    initial begin
        reset_L = 1'b0; valid_in0 = 1'b1; valid_in1 = 1'b1;
        data_in0 = 2'b01; data_in1 = 2'b10; ready_in = 1'b1;
        @(posedge clk); #1;
        advance();

`ifndef MUX_ARB_FIXED_PRIO_EN
        // Reset with both valid, contention bursts of 4, then backpressure mid-burst.
        vecs[0]  = mk(0, 1, 2'b01, 1, 2'b10, 1,  0, 0, 0, 0, 2'b00);
        vecs[1]  = mk(0, 1, 2'b01, 1, 2'b10, 1,  0, 0, 0, 0, 2'b00);
        vecs[2]  = mk(1, 1, 2'b01, 1, 2'b10, 1,  0, 0, 0, 0, 2'b00);
        vecs[3]  = mk(1, 1, 2'b01, 1, 2'b10, 1,  0, 1, 0, 0, 2'b00);
        vecs[4]  = mk(1, 1, 2'b01, 1, 2'b10, 1,  0, 1, 0, 1, 2'b01);
        vecs[5]  = mk(1, 1, 2'b01, 1, 2'b10, 1,  0, 1, 0, 1, 2'b01);
        vecs[6]  = mk(1, 1, 2'b01, 1, 2'b10, 1,  0, 1, 0, 1, 2'b01);
        vecs[7]  = mk(1, 1, 2'b01, 1, 2'b10, 1,  1, 0, 1, 1, 2'b01);
        vecs[8]  = mk(1, 1, 2'b01, 1, 2'b10, 1,  1, 0, 1, 1, 2'b10);
        vecs[9]  = mk(1, 1, 2'b01, 1, 2'b10, 1,  1, 0, 1, 1, 2'b10);
        vecs[10] = mk(1, 1, 2'b01, 1, 2'b10, 1,  1, 0, 1, 1, 2'b10);
        vecs[11] = mk(1, 1, 2'b01, 1, 2'b10, 1,  0, 1, 0, 1, 2'b10);
        vecs[12] = mk(1, 1, 2'b01, 1, 2'b10, 0,  0, 0, 0, 1, 2'b01);
        vecs[13] = mk(1, 1, 2'b01, 1, 2'b10, 0,  0, 0, 0, 1, 2'b01);
        vecs[14] = mk(1, 1, 2'b01, 1, 2'b10, 0,  0, 0, 0, 1, 2'b01);
        vecs[15] = mk(1, 1, 2'b01, 1, 2'b10, 1,  0, 1, 0, 1, 2'b01);
        vecs[16] = mk(1, 1, 2'b01, 1, 2'b10, 1,  0, 1, 0, 1, 2'b01);
        vecs[17] = mk(1, 1, 2'b01, 1, 2'b10, 1,  0, 1, 0, 1, 2'b01);
        vecs[18] = mk(1, 1, 2'b01, 1, 2'b10, 1,  1, 0, 1, 1, 2'b01);
        vecs[19] = mk(1, 1, 2'b01, 1, 2'b10, 1,  1, 0, 1, 1, 2'b10);
        for (int i = 0; i < 20; i++) begin
            reset_L = vecs[i].rst_n; valid_in0 = vecs[i].v0; data_in0 = vecs[i].d0;
            valid_in1 = vecs[i].v1; data_in1 = vecs[i].d1; ready_in = vecs[i].rdy;
            settle_check();
            chk($sformatf("vec%0d_sel", i),  32'(selector),   32'(vecs[i].e_sel));
            chk($sformatf("vec%0d_rdy0", i), 32'(ready_out0), 32'(vecs[i].e_r0));
            chk($sformatf("vec%0d_rdy1", i), 32'(ready_out1), 32'(vecs[i].e_r1));
            chk($sformatf("vec%0d_vout", i), 32'(valid_out),  32'(vecs[i].e_vo));
            chk($sformatf("vec%0d_dout", i), 32'(data_out),   32'(vecs[i].e_do));
            advance();
        end
`else
        // Fixed priority: with both inputs always valid only input 0 is served.
        reset_L = 1'b0; settle_check(); advance(); settle_check(); advance();
        reset_L = 1'b1;
        for (int i = 0; i < 14; i++) begin
            settle_check();
            chk("fixed_sel", 32'(selector), 32'd0);
            if (i >= 2) chk("fixed_dout", 32'(data_out), 32'(2'b01));
            advance();
        end
`endif

        // Single requester: input 1 alone, data stepping on each accept.
        valid_in0 = 1'b0; valid_in1 = 1'b1; data_in1 = '0; ready_in = 1'b1;
        do_reset();
        settle_check();
        chk("single_idle_sel", 32'(selector), 32'd0);
        advance();
        begin
            int accepted = 0;
            for (int k = 0; k < 7; k++) begin
                settle_check();
                chk("single_sel", 32'(selector), 32'd1);
                if (k == 0) chk("single_rdy1", 32'(ready_out1), 32'd1);
                if (k >= 1) begin
                    chk("single_vout", 32'(valid_out), 32'd1);
                    chk("single_dout", 32'(data_out), 32'((k - 1) % 4));
                end
                advance();
                if (m_acc1) begin
                    accepted++;
                    data_in1 = data_in1 + 1'b1;
                    if (accepted == 6) valid_in1 = 1'b0;
                end
            end
        end

        // Valid drop: input 0 leaves after 2 beats while input 1 waits.
        valid_in0 = 1'b1; data_in0 = 2'b01; valid_in1 = 1'b1; data_in1 = 2'b10; ready_in = 1'b1;
        do_reset();
        settle_check(); advance();
        settle_check(); chk("drop_grant0", 32'(ready_out0), 32'd1); advance();
        settle_check(); advance();
        valid_in0 = 1'b0;
        settle_check(); chk("drop_last_dout", 32'(data_out), 32'(2'b01)); advance();
        settle_check();
        chk("drop_bubble_vout", 32'(valid_out), 32'd0);
        chk("drop_sel", 32'(selector), 32'd1);
        advance();
        settle_check();
        chk("drop_in1_vout", 32'(valid_out), 32'd1);
        chk("drop_in1_dout", 32'(data_out), 32'(2'b10));
        advance();

        // Randomized traffic; requesters hold data until accepted, occasional reset.
        valid_in0 = 1'b0; valid_in1 = 1'b0;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            reset_L  = ($urandom % 200) != 0;
            ready_in = ($urandom % 4) != 0;
            settle_check();
            advance();
            if (!valid_in0 || m_acc0) begin
                valid_in0 = ($urandom % 3) != 0;
                data_in0  = WIDTH'($urandom);
            end
            if (!valid_in1 || m_acc1) begin
                valid_in1 = ($urandom % 3) != 0;
                data_in1  = WIDTH'($urandom);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
